// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder scheduler: one full-adder bit per clock, LSB first, with a done strobe.
// Optional self-checks compile in when SERIAL_ADD_ASSERT_EN is defined.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             bit_s;
  logic             bit_c;
  logic [WIDTH:0]   sum_ext;
  logic             accept;

  // Single full-adder cell operating on the current LSBs.
  assign bit_s   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign bit_c   = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
  // New bit enters at the MSB; slicing the extended vector also covers WIDTH == 1.
  assign sum_ext = {bit_s, sum_q};

  assign accept  = start & ((state_q == StIdle) | (state_q == StDone));

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        sum_d   = sum_ext[WIDTH:1];
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = bit_c;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          cout_d  = bit_c;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;

`ifdef SERIAL_ADD_ASSERT_EN
  // Shadow operands exist only to check the final result.
  logic [WIDTH-1:0] a_cap_q, b_cap_q;
  logic             cin_cap_q;
  logic [WIDTH:0]   ref_total;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_cap_q   <= '0;
      b_cap_q   <= '0;
      cin_cap_q <= 1'b0;
    end else if (accept) begin
      a_cap_q   <= a;
      b_cap_q   <= b;
      cin_cap_q <= cin;
    end
  end

  assign ref_total = {1'b0, a_cap_q} + {1'b0, b_cap_q} + {{WIDTH{1'b0}}, cin_cap_q};

  always_comb begin
    if (state_q == StRun) begin
      assert final (bit_s == ^{a_sh_q[0], b_sh_q[0], carry_q})
        else $error("serial_adder_ctrl: sum bit mismatch at %0t", $time);
      assert final (bit_c == ((a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) |
                              (b_sh_q[0] & carry_q)))
        else $error("serial_adder_ctrl: carry bit mismatch at %0t", $time);
    end
    if (done) begin
      assert final ({cout_q, sum_q} == ref_total)
        else $error("serial_adder_ctrl: result mismatch at %0t", $time);
    end
    assert final (!(done && busy))
      else $error("serial_adder_ctrl: done and busy both high at %0t", $time);
  end
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: WIDTH=8 main instance plus a WIDTH=1 instance.
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  logic start1, a1, b1, cin1, busy1, done1, sum1, cout1;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk  (clk),
    .rst  (rst),
    .start(start1),
    .a    (a1),
    .b    (b1),
    .cin  (cin1),
    .busy (busy1),
    .done (done1),
    .sum  (sum1),
    .cout (cout1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W:0] total;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation, on time.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done=1 expected no done at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          check("result", {cout, sum}, e.total);
          check("done_cycle", cyc, e.due);
          check("busy_with_done", busy, 1'b0);
        end
      end else if (sb.size() > 0 && sb[0].due < cyc) begin
        checks++;
        failures++;
        $display("FAIL missed_done: got no done expected done at cycle %0d", sb[0].due);
        void'(sb.pop_front());
      end
    end
  end

  // Issue one operation at the current negedge; returns at the negedge where done is due.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                        input bit hold, output logic [W:0] total);
    exp_t e;
    start = 1'b1;
    a     = ia;
    b     = ib;
    cin   = ic;
    total = {1'b0, ia} + {1'b0, ib} + {{W{1'b0}}, ic};
    e.total = total;
    e.due   = cyc + 1 + W;
    sb.push_back(e);
    @(negedge clk);
    if (!hold) start = 1'b0;
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom);
    for (int i = 0; i < W; i++) begin
      check("busy_run", busy, 1'b1);
      @(negedge clk);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [W:0] tot;
    int         gap;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_sum", sum, '0);
    check("reset_cout", cout, 1'b0);
    check("reset_done_w1", done1, 1'b0);
    rst = 1'b0;

    // Directed: first edge after reset release accepts.
    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, tot);
    check("sum_5a_3c", {cout, sum}, 9'h096);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, tot);
    run_op(8'hFF, 8'h00, 1'b1, 1'b0, tot);
    @(negedge clk);
    check("hold_ff_00_1", {cout, sum}, 9'h100);
    @(negedge clk);

    // Start held high: RUN ignores it, DONE re-accepts back to back.
    for (int k = 0; k < 4; k++) run_op(8'h01, 8'h01, 1'b0, 1'b1, tot);
    start = 1'b0;
    @(negedge clk);
    check("hold_after_b2b", {cout, sum}, 9'h002);

    // Abort mid-run: no done, outputs clear at once.
    start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_before_abort", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_sum", sum, '0);
    check("abort_cout", cout, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run_op(8'h10, 8'h20, 1'b0, 1'b0, tot);
    check("sum_after_abort", {cout, sum}, 9'h030);

    // Random operations with random idle gaps (gap 0 means accept in DONE).
    for (int n = 0; n < 300; n++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, tot);
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        check("sum_hold", {cout, sum}, tot);
      end
    end
    start = 1'b0;
    repeat (W + 2) @(negedge clk);

    // WIDTH=1 instance: all input combinations, done two cycles after start is driven.
    for (int k = 0; k < 8; k++) begin
      logic [2:0] kv;
      logic [1:0] ref1;
      kv   = 3'(k);
      ref1 = 2'(kv[2]) + 2'(kv[1]) + 2'(kv[0]);
      a1 = kv[2]; b1 = kv[1]; cin1 = kv[0];
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      a1 = ~a1; b1 = ~b1; cin1 = ~cin1;
      check("w1_busy", busy1, 1'b1);
      check("w1_not_done", done1, 1'b0);
      @(negedge clk);
      check("w1_done", done1, 1'b1);
      check("w1_busy_low", busy1, 1'b0);
      check("w1_result", {cout1, sum1}, ref1);
    end

    repeat (2) @(negedge clk);
    check("scoreboard_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller that sequences a single one-bit full-adder cell over a WIDTH-bit operand pair, one bit per clock, LSB first. It latches operands on a start pulse, runs the carry chain through a registered carry flop, and presents the WIDTH-bit sum and carry-out with a one-cycle done strobe. It sits beside the combinational full adder as its scheduler, trading area for latency in arithmetic paths that are not timing-critical.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 1..64
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled on rising clk edge
- a  input  WIDTH  operand A; captured when start is accepted
- b  input  WIDTH  operand B; captured when start is accepted
- cin  input  1  carry-in; captured when start is accepted
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle strobe; sum/cout valid
- sum  output  WIDTH  result, held until next accepted start
- cout  output  1  final carry, held with sum

## Operation
- States: IDLE, RUN, DONE; 2-bit encoded; reset state IDLE.
- IDLE: start=1 accepts. Load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, clear sum/cout; go RUN.
- RUN, each cycle:
  - s = a_sh[0]^b_sh[0]^carry
  - c = majority(a_sh[0], b_sh[0], carry)
  - sum shifts right, s enters at MSB
  - a_sh/b_sh shift right; carry<=c; cnt<=cnt+1
  - when cnt==WIDTH-1, cout<=c and go DONE.
- DONE: done=1 for exactly this cycle.
  - start=1 in DONE is accepted: reload as from IDLE, go RUN; sum/cout clear on that edge.
  - Otherwise go IDLE; sum/cout hold.
- start in RUN is ignored; no queueing.
- cnt width: $clog2(WIDTH+1); never wraps within an operation.
- Result equals (a+b+cin) mod 2^WIDTH, cout the bit WIDTH of the full sum.
- Operand inputs may change freely after acceptance; only captured copies are used.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, state IDLE, internal shift and carry regs 0.
- Reset asserted mid-RUN aborts immediately. No done is produced for the aborted operation.
- After reset deasserts, the first rising edge with start=1 is accepted.
- Start accepted at edge E0.
  - busy=1 from after E0 to after edge E0+WIDTH.
  - Bit i is computed in the cycle after edge E0+i.
  - done=1 in the cycle after edge E0+WIDTH, and busy=0 in that cycle.
- Start-to-done latency: WIDTH+1 cycles. Throughput: one operation per WIDTH+1 cycles.
- sum/cout are registered and glitch-free.
- sum/cout are only meaningful once done has been seen. Intermediate partial values are visible during RUN.

## Configuration
- SERIAL_ADD_ASSERT_EN defined:
  - Compiles in checks as final deferred immediate assertions, evaluated in the postponed region.
  - Per RUN cycle: computed s/c match the XOR and majority functions of the current a_sh[0], b_sh[0], carry.
  - At done: {cout,sum} equals captured a+b+cin, using shadow copies kept only under the macro.
  - At all times: done and busy are never high together.
  - Failures call $error with $time; passes are silent.
- Undefined: no assertions, no shadow registers. Functional behaviour is identical.

## Test plan
- WIDTH=8; a=0x5A, b=0x3C, cin=0, start pulse -> busy for 8 cycles, done 9 cycles after start, sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
- Start held high continuously with a=0x01, b=0x01, cin=0:
  - Start pulses in RUN are ignored.
  - Back-to-back accept in DONE gives one done every 9 cycles, each with sum=0x02.
- Assert rst 4 cycles into an operation (a=0xAA, b=0x55):
  - busy, done, sum, cout all go 0 at once, with no done.
  - Next operation a=0x10, b=0x20 -> sum=0x30.
- WIDTH=1 build:
  - All 8 {a,b,cin} combinations.
  - Each gives done 2 cycles after start with {cout,sum} = a+b+cin.
- SERIAL_ADD_ASSERT_EN defined, 1000 random operand triples: zero assertion failures, and every result matches the reference sum.
